instr_fetch_unit: RTL and testbench

Multi-cycle instruction fetch stage sitting directly downstream of the 13-bit program counter. On a controller request it latches the current PC value as a memory address, runs a read handshake against instruction memory with variable latency, captures the returned word into the instruction register, and pulses the PC increment strobe. It also handles jump flushes mid-fetch and a bounded-wait timeout that traps into a sticky error state.

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: latches PC as the read address, handshakes with
// variable-latency instruction memory, fills the instruction register and strobes PC increment.
module instr_fetch_unit #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_req,
  input  logic              flush,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              pc_inc,
  output logic              busy,
  output logic              fetch_err,
  output logic [2:0]        dbg_state
);

  // Handshake: mem_rd rises with a stable mem_addr and is held until the cycle
  // mem_ready=1 is sampled (or the wait budget expires); ir_valid stays high
  // until ir_ack or flush is sampled.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic                mem_rd_n, ir_valid_n, pc_inc_n, fetch_err_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   ir_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      pc_inc    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_rd    <= mem_rd_n;
      mem_addr  <= mem_addr_n;
      ir        <= ir_n;
      ir_valid  <= ir_valid_n;
      pc_inc    <= pc_inc_n;
      fetch_err <= fetch_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mem_rd_n    = mem_rd;
    mem_addr_n  = mem_addr;
    ir_n        = ir;
    ir_valid_n  = ir_valid;
    pc_inc_n    = 1'b0;
    fetch_err_n = fetch_err;
    unique case (state)
      IDLE: begin
        if (fetch_req && !flush) begin
          mem_addr_n = pc_addr;
          mem_rd_n   = 1'b1;
          cnt_n      = '0;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_rd_n = 1'b0;
          if (flush) begin
            state_n = IDLE;
          end else begin
            ir_n       = mem_rdata;
            ir_valid_n = 1'b1;
            pc_inc_n   = 1'b1;
            state_n    = HOLD;
          end
        end else if (cnt == CNT_LAST) begin
          mem_rd_n    = 1'b0;
          fetch_err_n = 1'b1;
          state_n     = ERR;
        end else begin
          // A flushed request keeps mem_rd up; the memory must still complete it.
          cnt_n = cnt + 8'd1;
          if (flush) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          mem_rd_n = 1'b0;
          state_n  = IDLE;
        end else if (cnt == CNT_LAST) begin
          mem_rd_n    = 1'b0;
          fetch_err_n = 1'b1;
          state_n     = ERR;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      HOLD: begin
        if (ir_ack || flush) begin
          ir_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end
      ERR: begin
        mem_rd_n   = 1'b0;
        ir_valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed expectations for fetch latency,
// flush/drain handling, wait-budget trap and reset behaviour.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] pc_addr = '0;
  logic              fetch_req = 1'b0;
  logic              flush = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ack = 1'b0;
  logic              pc_inc;
  logic              busy;
  logic              fetch_err;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int inc_cnt = 0;
  int c_first = 0;
  int rd_base = 0;
  int inc_base = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_addr   (pc_addr),
    .fetch_req (fetch_req),
    .flush     (flush),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ack    (ir_ack),
    .pc_inc    (pc_inc),
    .busy      (busy),
    .fetch_err (fetch_err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // One clock, then observe registered outputs 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_rd) rd_cnt++;
    if (pc_inc) inc_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_pc_inc", 32'(pc_inc), 0);
    check("rst_fetch_err", 32'(fetch_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    tick();
    rd_cnt = 0;
    inc_cnt = 0;

    // Fetch with 3 wait cycles
    pc_addr   = 13'h0A5;
    fetch_req = 1'b1;
    tick();
    check("t1_mem_rd", 32'(mem_rd), 1);
    check("t1_mem_addr", 32'(mem_addr), 32'h0A5);
    check("t1_busy", 32'(busy), 1);
    fetch_req = 1'b0;
    tick();
    tick();
    tick();
    check("t1_still_rd", 32'(mem_rd), 1);
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ready = 1'b0;
    check("t1_ir", 32'(ir), 32'hBEEF);
    check("t1_ir_valid", 32'(ir_valid), 1);
    check("t1_pc_inc", 32'(pc_inc), 1);
    check("t1_rd_low", 32'(mem_rd), 0);
    check("t1_state", 32'(dbg_state), 32'(S_HOLD));
    tick();
    check("t1_pc_inc_off", 32'(pc_inc), 0);
    check("t1_ir_valid_hold", 32'(ir_valid), 1);
    check("t1_rd_cycles", 32'(rd_cnt), 4);
    check("t1_inc_pulses", 32'(inc_cnt), 1);
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    check("t1_ack_valid", 32'(ir_valid), 0);
    check("t1_ack_idle", 32'(busy), 0);
    check("t1_ir_kept", 32'(ir), 32'hBEEF);

    // Zero-wait fetch, back-to-back with fetch_req held
    pc_addr   = 13'h100;
    fetch_req = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    c_first = cyc;
    check("t2_mem_rd", 32'(mem_rd), 1);
    check("t2_mem_addr", 32'(mem_addr), 32'h100);
    pc_addr = 13'h1FF;
    tick();
    check("t2_addr_stable", 32'(mem_addr), 32'h100);
    check("t2_ir", 32'(ir), 32'h1111);
    check("t2_pc_inc", 32'(pc_inc), 1);
    mem_rdata = 16'h2222;
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    check("t2_idle", 32'(dbg_state), 32'(S_IDLE));
    tick();
    check("t2_second_rd", 32'(mem_rd), 1);
    check("t2_spacing", 32'(cyc - c_first), 3);
    check("t2_second_addr", 32'(mem_addr), 32'h1FF);
    fetch_req = 1'b0;
    tick();
    mem_ready = 1'b0;
    check("t2_second_ir", 32'(ir), 32'h2222);
    tick();
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    check("t2_done", 32'(busy), 0);

    // Flush one cycle into REQ -> DRAIN
    inc_base  = inc_cnt;
    pc_addr   = 13'h0300;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_drain", 32'(dbg_state), 32'(S_DRAIN));
    check("t3_drain_rd", 32'(mem_rd), 1);
    check("t3_drain_addr", 32'(mem_addr), 32'h0300);
    tick();
    check("t3_drain_rd2", 32'(mem_rd), 1);
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    mem_ready = 1'b0;
    check("t3_rd_low", 32'(mem_rd), 0);
    check("t3_ir_unchanged", 32'(ir), 32'h2222);
    check("t3_ir_valid", 32'(ir_valid), 0);
    check("t3_idle", 32'(busy), 0);
    check("t3_no_inc", 32'(inc_cnt - inc_base), 0);

    // Flush coincident with mem_ready in REQ
    pc_addr   = 13'h044;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    flush     = 1'b0;
    mem_ready = 1'b0;
    check("t4_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t4_rd_low", 32'(mem_rd), 0);
    check("t4_ir", 32'(ir), 32'h2222);
    check("t4_ir_valid", 32'(ir_valid), 0);

    // Flush coincident with fetch_req in IDLE
    pc_addr   = 13'h055;
    fetch_req = 1'b1;
    flush     = 1'b1;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b0;
    check("t4b_rd", 32'(mem_rd), 0);
    check("t4b_busy", 32'(busy), 0);
    check("t4b_addr", 32'(mem_addr), 32'h044);
    check("t4_no_inc", 32'(inc_cnt - inc_base), 0);

    // Reset while holding a valid instruction
    pc_addr   = 13'h0777;
    fetch_req = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hCAFE;
    tick();
    fetch_req = 1'b0;
    tick();
    mem_ready = 1'b0;
    check("t6_hold_ir", 32'(ir), 32'hCAFE);
    check("t6_hold_valid", 32'(ir_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_ir", 32'(ir), 0);
    check("t6_ir_valid", 32'(ir_valid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_addr", 32'(mem_addr), 0);

    // Timeout from REQ
    rd_base   = rd_cnt;
    pc_addr   = 13'h0ABC;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    tick();
    check("t5_rd_last", 32'(mem_rd), 1);
    check("t5_no_err_yet", 32'(fetch_err), 0);
    tick();
    check("t5_rd_cycles", 32'(rd_cnt - rd_base), TIMEOUT);
    check("t5_rd_low", 32'(mem_rd), 0);
    check("t5_err", 32'(fetch_err), 1);
    check("t5_busy", 32'(busy), 1);
    check("t5_state", 32'(dbg_state), 32'(S_ERR));
    fetch_req = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    fetch_req = 1'b0;
    mem_ready = 1'b0;
    check("t5_ignored_rd", 32'(mem_rd), 0);
    check("t5_sticky", 32'(fetch_err), 1);
    check("t5_ir_valid", 32'(ir_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_err", 32'(fetch_err), 0);
    check("t5_rst_busy", 32'(busy), 0);

    // Timeout from DRAIN (wait count carries over from REQ)
    rd_base   = rd_cnt;
    pc_addr   = 13'h1000;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check("t7_drain", 32'(dbg_state), 32'(S_DRAIN));
    tick();
    tick();
    tick();
    check("t7_rd_cycles", 32'(rd_cnt - rd_base), TIMEOUT);
    check("t7_err", 32'(fetch_err), 1);
    check("t7_rd_low", 32'(mem_rd), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_rst_state", 32'(dbg_state), 32'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
